// File: rtl/serial_tx_buffered.sv
// serial_tx_buffered: 8N1 UART transmitter fed by a small byte FIFO.
// Upstream strobes bytes in, tx_busy signals a full FIFO, and overflow
// latches any strobe that arrived while the FIFO was full.
module serial_tx_buffered #(
  parameter int unsigned CLK_PER_BIT = 50,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  input  logic       block,
  output logic       tx_busy,
  output logic       tx,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNTW  = FIFO_AW + 1;
  localparam int unsigned CW    = $clog2(CLK_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;

  logic [7:0]           mem [DEPTH];

  logic                 full;
  logic                 wr_en;
  logic                 pop;
  logic                 can_start;
  logic                 bit_end;

  assign full      = (count_q == CNTW'(DEPTH));
  assign wr_en     = new_tx_data && !full;
  assign can_start = (count_q != '0) && !block;
  assign bit_end   = (cyc_q == CW'(CLK_PER_BIT - 1));

  // FIFO storage; no reset needed since the count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  // Frame sequencing, line value and FIFO bookkeeping for the next edge.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cyc_d = '0;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          bit_d   = 3'd0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cyc_d = cyc_q + CW'(1);
          tx_d  = 1'b0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (can_start) begin
            // Back-to-back frame: start bit follows the last stop cycle.
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            bit_d   = 3'd0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
          tx_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    wr_ptr_d = wr_en ? (wr_ptr_q + FIFO_AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop   ? (rd_ptr_q + FIFO_AW'(1)) : rd_ptr_q;
    count_d  = count_q + CNTW'(wr_en) - CNTW'(pop);
    busy_d   = (count_d == CNTW'(DEPTH));
    ovf_d    = ovf_q | (new_tx_data & full);
  end

  // State register; reset abandons any partial frame and empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Bench for serial_tx_buffered: queue-based reference model compared every
// cycle, plus directed scenarios with hand-written line expectations.
module tb_serial_tx_buffered;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FL    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       block;
  logic       tx_busy;
  logic       tx;
  logic       overflow;

  always #5 clk = ~clk;

  serial_tx_buffered #(.CLK_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .new_tx_data(new_tx_data),
    .block      (block),
    .tx_busy    (tx_busy),
    .tx         (tx),
    .overflow   (overflow)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endfunction

  // Line value at cycle offset i of an 8N1 frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int seg;
    seg = i / int'(CPB);
    if (seg == 0) return 1'b0;
    if (seg >= 9) return 1'b1;
    return b[seg-1];
  endfunction

  // Reference model: byte queue plus "frame in flight since cycle offset".
  logic [7:0] mq[$];
  bit         m_act;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;

  task automatic model_reset();
    mq.delete();
    m_act = 1'b0;
    m_pos = 0;
    m_cur = 8'd0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int n;
    bit start;
    n     = mq.size();
    start = 1'b0;
    if (m_act) begin
      if (m_pos == int'(FL) - 1) begin
        m_act = 1'b0;
        start = (n > 0) && !block;
      end else begin
        m_pos++;
      end
    end else begin
      start = (n > 0) && !block;
    end
    if (start) begin
      m_cur = mq.pop_front();
      m_act = 1'b1;
      m_pos = 0;
    end
    if (new_tx_data && n < int'(DEPTH)) mq.push_back(tx_data);
    if (new_tx_data && n >= int'(DEPTH)) m_ovf = 1'b1;
  endtask

  function automatic logic model_tx();
    if (!m_act) return 1'b1;
    return frame_bit(m_cur, m_pos);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_tx", tx, model_tx());
      chk("model_busy", tx_busy, mq.size() == int'(DEPTH));
      chk("model_ovf", overflow, m_ovf);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [7:0] b);
    new_tx_data = 1'b1;
    tx_data     = b;
    tick();
    new_tx_data = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] b);
    for (int i = 0; i < int'(FL); i++) begin
      tick();
      chk("frame_bit", tx, frame_bit(b, i));
    end
  endtask

  initial begin
    rst         = 1'b0;
    new_tx_data = 1'b0;
    tx_data     = 8'd0;
    block       = 1'b0;
    repeat (3) tick();
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    rst    = 1'b1;
    chk_en = 1'b1;
    tick();

    // Single byte: two-cycle latency then 0,1,0,1,... pattern.
    strobe(8'h55);
    chk("latency_idle", tx, 1'b1);
    begin
      logic [9:0] pat;
      pat = 10'b1010101010;
      for (int i = 0; i < int'(FL); i++) begin
        tick();
        chk("pat55", tx, pat[i / int'(CPB)]);
      end
    end
    tick();
    chk("idle_after_55", tx, 1'b1);

    // Burst of five into a held FIFO: fifth dropped, four frames back-to-back.
    chk("ovf_before_burst", overflow, 1'b0);
    block = 1'b1;
    for (int i = 0; i < 5; i++) begin
      new_tx_data = 1'b1;
      tx_data     = 8'(8'h30 + i);
      tick();
      if (i == 3) chk("busy_full", tx_busy, 1'b1);
    end
    new_tx_data = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    block = 1'b0;
    for (int i = 0; i < 4; i++) expect_frame(8'(8'h30 + i));
    tick();
    chk("burst_idle", tx, 1'b1);
    chk("burst_busy_clr", tx_busy, 1'b0);

    // Block holds the line idle; release starts on the next cycle.
    block = 1'b1;
    strobe(8'h41);
    repeat (30) begin
      tick();
      chk("blocked_idle", tx, 1'b1);
    end
    block = 1'b0;
    tick();
    chk("unblock_start", tx, 1'b0);
    repeat (FL) tick();

    // Block raised mid-frame: current frame completes, next one waits.
    strobe(8'h0F);
    strobe(8'hAA);
    repeat (17) tick();
    block = 1'b1;
    for (int i = 18; i < int'(FL); i++) begin
      tick();
      chk("midblock_frame", tx, frame_bit(8'h0F, i));
    end
    repeat (20) begin
      tick();
      chk("block_hold", tx, 1'b1);
    end
    block = 1'b0;
    tick();
    chk("resume_start", tx, 1'b0);
    for (int i = 1; i < int'(FL); i++) begin
      tick();
      chk("resume_frame", tx, frame_bit(8'hAA, i));
    end
    tick();

    // Reset during data bit 5 with two bytes queued.
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    repeat (24) tick();
    chk("pre_reset_bit5", tx, 1'b0);
    chk("pre_reset_ovf", overflow, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    repeat (60) begin
      tick();
      chk("post_reset_idle", tx, 1'b1);
    end

    // Count of three with a write on the pop edge.
    block = 1'b1;
    strobe(8'h01);
    strobe(8'h02);
    strobe(8'h03);
    chk("three_not_busy", tx_busy, 1'b0);
    block       = 1'b0;
    new_tx_data = 1'b1;
    tx_data     = 8'h04;
    tick();
    new_tx_data = 1'b0;
    chk("samepop_busy", tx_busy, 1'b0);
    chk("samepop_ovf", overflow, 1'b0);
    chk("samepop_start", tx, 1'b0);
    tick();
    chk("samepop_busy2", tx_busy, 1'b0);
    repeat (4 * FL + 10) tick();

    // Randomized traffic with block toggling and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      new_tx_data = ($urandom_range(0, 5) == 0);
      tx_data     = 8'($urandom);
      if ($urandom_range(0, 40) == 0) block = ~block;
      if (c == 1500) rst = 1'b0;
      if (c == 1503) rst = 1'b1;
      tick();
    end
    new_tx_data = 1'b0;
    block       = 1'b0;
    repeat (5 * FL) tick();
    chk("drained_idle", tx, 1'b1);
    chk("drained_busy", tx_busy, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
